// File: rtl/lcd_text_buffer.sv
// Double-buffered 32-character text store feeding the LCD sequencer.
// The host fills a shadow copy, which is committed to the active copy only on a frame boundary.
module lcd_text_buffer #(
  parameter logic [7:0] CLR_CHAR = 8'h20
) (
  input  logic        lcdclk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        commit,
  input  logic        clear,
  input  logic        frame_done,
  input  logic [4:0]  rd_idx,
  output logic [7:0]  rd_char,
  output logic        busy,
  output logic        pending,
  output logic        updated
);

  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_FRAME, COPY} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        latch_q, latch_d;
  logic        updated_q;
  logic [7:0]  rd_char_q;
  logic [31:0] shadow_q [8];
  logic [31:0] shadow_d [8];
  logic [31:0] active_q [8];
  logic [31:0] active_d [8];

  always_ff @(posedge lcdclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

  // A commit arriving on the last clear cycle still counts as latched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = 3'd0;
          latch_d = commit;
        end else if (commit) begin
          state_d = WAIT_FRAME;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 3'd1;
        if (commit) latch_d = 1'b1;
        if (cnt_q == 3'd7) begin
          cnt_d   = 3'd0;
          latch_d = 1'b0;
          state_d = (latch_q || commit) ? WAIT_FRAME : IDLE;
        end
      end
      WAIT_FRAME: begin
        if (frame_done) state_d = COPY;
      end
      COPY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    pending = (state_q == WAIT_FRAME) || ((state_q == CLEAR) && latch_q);
    updated = updated_q;
    rd_char = rd_char_q;
  end

  // COPY samples the shadow from before this cycle's host write.
  always_comb begin
    for (int w = 0; w < 8; w++) begin
      shadow_d[w] = shadow_q[w];
      active_d[w] = (state_q == COPY) ? shadow_q[w] : active_q[w];
    end
    if (state_q == CLEAR) begin
      shadow_d[cnt_q] = {4{CLR_CHAR}};
    end else if (wr_en) begin
      shadow_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge lcdclk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < 8; w++) begin
        shadow_q[w] <= {4{CLR_CHAR}};
        active_q[w] <= {4{CLR_CHAR}};
      end
      updated_q <= 1'b0;
      rd_char_q <= CLR_CHAR;
    end else begin
      for (int w = 0; w < 8; w++) begin
        shadow_q[w] <= shadow_d[w];
        active_q[w] <= active_d[w];
      end
      updated_q <= (state_q == COPY);
      rd_char_q <= active_q[rd_idx[4:2]][{~rd_idx[1:0], 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Randomized and directed checks of lcd_text_buffer against a character-level model.
module tb_lcd_text_buffer;

  logic        lcdclk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [31:0] wr_data = 32'd0;
  logic        commit = 1'b0;
  logic        clear = 1'b0;
  logic        frame_done = 1'b0;
  logic [4:0]  rd_idx = 5'd0;
  logic [7:0]  rd_char;
  logic        busy, pending, updated;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] mShadow [32];
  logic [7:0] mActive [32];
  int         clearLeft, clearPos;
  bit         clrCommit, waiting, copyNext;
  logic [7:0] mRdChar;
  logic       mUpdated;

  lcd_text_buffer #(.CLR_CHAR(8'h20)) dut (
    .lcdclk(lcdclk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .clear(clear), .frame_done(frame_done),
    .rd_idx(rd_idx), .rd_char(rd_char), .busy(busy), .pending(pending),
    .updated(updated)
  );

  always #5 lcdclk = ~lcdclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 32; i++) begin
      mShadow[i] = 8'h20;
      mActive[i] = 8'h20;
    end
    clearLeft = 0; clearPos = 0;
    clrCommit = 0; waiting = 0; copyNext = 0;
    mRdChar = 8'h20; mUpdated = 1'b0;
  endfunction

  // One clock edge of behaviour, expressed on individual characters.
  function automatic void modelStep();
    bit wasCopy = copyNext;
    bit wasClearing = (clearLeft > 0);
    bit wasWaiting = waiting;
    mRdChar  = mActive[rd_idx];
    mUpdated = wasCopy;
    if (wasCopy) begin
      for (int i = 0; i < 32; i++) mActive[i] = mShadow[i];
      copyNext = 0;
    end
    if (wasClearing) begin
      for (int k = 0; k < 4; k++) mShadow[clearPos*4 + k] = 8'h20;
      clearPos++;
      clearLeft--;
      if (commit) clrCommit = 1;
      if (clearLeft == 0) begin
        waiting   = clrCommit;
        clrCommit = 0;
      end
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++) mShadow[wr_addr*4 + k] = wr_data[31 - 8*k -: 8];
    end
    if (wasWaiting && frame_done) begin
      waiting  = 0;
      copyNext = 1;
    end
    if (!wasCopy && !wasClearing && !wasWaiting) begin
      if (clear) begin
        clearLeft = 8; clearPos = 0; clrCommit = commit;
      end else if (commit) begin
        waiting = 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge lcdclk);
    modelStep();
    #1;
    checkOutput("rd_char", {24'd0, rd_char}, {24'd0, mRdChar});
    checkOutput("busy", {31'd0, busy}, {31'd0, (clearLeft > 0) || waiting || copyNext});
    checkOutput("pending", {31'd0, pending}, {31'd0, waiting || ((clearLeft > 0) && clrCommit)});
    checkOutput("updated", {31'd0, updated}, {31'd0, mUpdated});
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [31:0] data,
                               input logic cm, input logic cl, input logic fd, input logic [4:0] idx);
    wr_en = we; wr_addr = addr; wr_data = data;
    commit = cm; clear = cl; frame_done = fd; rd_idx = idx;
    tick();
    wr_en = 1'b0; commit = 1'b0; clear = 1'b0; frame_done = 1'b0;
  endtask

  task automatic idle(input int n, input logic [4:0] idx);
    for (int i = 0; i < n; i++) applyStimulus(0, 3'd0, 32'd0, 0, 0, 0, idx);
  endtask

  task automatic applyReset();
    wr_en = 1'b0; commit = 1'b0; clear = 1'b0; frame_done = 1'b0;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_rd_char", {24'd0, rd_char}, 32'h20);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_pending", {31'd0, pending}, 32'd0);
    checkOutput("rst_updated", {31'd0, updated}, 32'd0);
    #1;
    reset = 1'b0;
  endtask

  task automatic readRange(input string tag, input int first, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 3'd0, 32'd0, 0, 0, 0, 5'(first + i));
      checkOutput(tag, {24'd0, rd_char}, {24'd0, word[31 - 8*i -: 8]});
    end
  endtask

  initial begin
    int updCount;
    modelReset();
    #2;
    applyReset();

    // Reset while waiting for a frame drops the commit.
    applyStimulus(1, 3'd0, 32'h54657874, 0, 0, 0, 5'd0);
    applyStimulus(0, 3'd0, 32'd0, 1, 0, 0, 5'd0);
    idle(2, 5'd0);
    applyReset();
    readRange("t1_read", 0, 32'h20202020);
    applyStimulus(0, 3'd0, 32'd0, 0, 0, 1, 5'd0);
    updCount = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1, 5'd0);
      if (updated) updCount++;
    end
    checkOutput("t1_no_updated", updCount, 0);

    // Basic commit; updated arrives two cycles after frame_done.
    applyStimulus(1, 3'd0, 32'h54657874, 0, 0, 0, 5'd0);
    applyStimulus(0, 3'd0, 32'd0, 1, 0, 0, 5'd0);
    idle(4, 5'd0);
    applyStimulus(0, 3'd0, 32'd0, 0, 0, 1, 5'd0);
    checkOutput("t2_upd_f1", {31'd0, updated}, 32'd0);
    idle(1, 5'd0);
    checkOutput("t2_upd_f2", {31'd0, updated}, 32'd1);
    idle(1, 5'd0);
    checkOutput("t2_upd_f3", {31'd0, updated}, 32'd0);
    readRange("t2_read", 0, 32'h54657874);
    readRange("t2_read4", 4, 32'h20202020);

    // frame_done alongside the commit is not the copy frame.
    applyStimulus(1, 3'd0, 32'h41424344, 0, 0, 0, 5'd1);
    applyStimulus(0, 3'd0, 32'd0, 1, 0, 1, 5'd1);
    idle(2, 5'd1);
    checkOutput("t3_still_wait", {31'd0, pending}, 32'd1);
    checkOutput("t3_old_char", {24'd0, rd_char}, 32'h65);
    applyStimulus(0, 3'd0, 32'd0, 0, 0, 1, 5'd1);
    idle(2, 5'd1);
    checkOutput("t3_new_char", {24'd0, rd_char}, 32'h42);

    // clear+commit wipes the shadow and commits the blank screen.
    applyStimulus(1, 3'd4, 32'h536f4320, 1, 0, 0, 5'd16);
    applyStimulus(0, 3'd0, 32'd0, 0, 0, 1, 5'd16);
    idle(2, 5'd16);
    readRange("t4_soc", 16, 32'h536f4320);
    for (int w = 0; w < 8; w++) applyStimulus(1, 3'(w), 32'h41414141, 0, 0, 0, 5'd0);
    applyStimulus(0, 3'd0, 32'd0, 1, 1, 0, 5'd0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t4_busy", {31'd0, busy}, 32'd1);
      if (i < 7) idle(1, 5'd0);
    end
    idle(1, 5'd0);
    checkOutput("t4_wait", {31'd0, pending}, 32'd1);
    applyStimulus(0, 3'd0, 32'd0, 0, 0, 1, 5'd0);
    idle(2, 5'd0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 3'd0, 32'd0, 0, 0, 0, 5'(i));
      checkOutput("t4_blank", {24'd0, rd_char}, 32'h20);
    end

    // Writes in the frame_done cycle are copied; writes in COPY are not.
    applyStimulus(0, 3'd0, 32'd0, 1, 0, 0, 5'd0);
    idle(1, 5'd0);
    applyStimulus(1, 3'd7, 32'h4c616220, 0, 0, 1, 5'd0);
    applyStimulus(1, 3'd1, 32'h31323334, 0, 0, 0, 5'd0);
    idle(1, 5'd0);
    readRange("t5_lab", 28, 32'h4c616220);
    readRange("t5_copy_wr", 4, 32'h20202020);
    applyStimulus(0, 3'd0, 32'd0, 1, 0, 0, 5'd0);
    idle(1, 5'd0);
    applyStimulus(0, 3'd0, 32'd0, 0, 0, 1, 5'd0);
    idle(2, 5'd0);
    readRange("t5_next", 4, 32'h31323334);

    // Host writes during CLEAR are dropped; index 31 is read throughout.
    applyStimulus(0, 3'd0, 32'd0, 0, 1, 0, 5'd31);
    idle(2, 5'd31);
    applyStimulus(1, 3'd2, 32'h58585858, 0, 0, 0, 5'd31);
    idle(6, 5'd31);
    checkOutput("t6_idle", {31'd0, busy}, 32'd0);
    applyStimulus(0, 3'd0, 32'd0, 1, 0, 0, 5'd31);
    applyStimulus(0, 3'd0, 32'd0, 0, 0, 1, 5'd31);
    idle(2, 5'd31);
    readRange("t6_dropped", 8, 32'h20202020);

    // Random traffic, including occasional mid-operation reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) applyReset();
      applyStimulus($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 7) == 0, 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
